// File: rtl/tts_pkg.sv
// Shared types and sizing constants for the truth-table sweep engine.
package tts_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  localparam int CODE_W     = 4;
  localparam int NUM_CODES  = 16;
  localparam int MISMATCH_W = 5;
endpackage

// File: rtl/truth_table_sweep_if.sv
// Stimulus/response bundle between the sweep engine and the unit under test.
interface truth_table_sweep_if;
  import tts_pkg::*;

  logic                  start;
  logic                  A;
  logic                  B;
  logic                  C;
  logic                  D;
  logic                  y_in;
  logic                  busy;
  logic                  done;
  logic [NUM_CODES-1:0]  table_out;
  logic                  pass;
  logic [MISMATCH_W-1:0] mismatch_cnt;

  modport master (
    input  start, y_in,
    output A, B, C, D, busy, done, table_out, pass, mismatch_cnt
  );

  modport slave (
    output start, y_in,
    input  A, B, C, D, busy, done, table_out, pass, mismatch_cnt
  );
endinterface

// File: rtl/sweep_dwell_timer.sv
// Per-code hold counter; last flags the cycle in which the response is sampled.
module sweep_dwell_timer #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);
  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign last = (cnt == 8'(DWELL - 1));
endmodule

// File: rtl/truth_table_sweep.sv
// Drives all 16 {A,B,C,D} codes, captures the response table and grades it
// against EXPECTED.
module truth_table_sweep
  import tts_pkg::*;
#(
  parameter int                   DWELL    = 4,
  parameter logic [NUM_CODES-1:0] EXPECTED = 16'h0040
) (
  input  logic                clk,
  input  logic                rst,
  truth_table_sweep_if.master bus
);
  state_t                state;
  logic [CODE_W-1:0]     code;
  logic [NUM_CODES-1:0]  acc;
  logic [NUM_CODES-1:0]  acc_nxt;
  logic [MISMATCH_W-1:0] mism;
  logic [MISMATCH_W-1:0] mism_nxt;
  logic                  busy;
  logic                  done;
  logic [NUM_CODES-1:0]  table_q;
  logic                  pass;
  logic [MISMATCH_W-1:0] mism_cnt_q;
  logic                  last;
  logic                  running;
  logic                  accept;
  logic                  sample;
  logic                  miss;

  assign running = (state == RUN);
  // The done cycle (FINISH) accepts start exactly like IDLE.
  assign accept  = !running && bus.start;
  assign sample  = running && last;
  assign miss    = (bus.y_in != EXPECTED[code]);

  // Results published on the final sample must include that sample's bit.
  always_comb begin
    acc_nxt       = acc;
    acc_nxt[code] = bus.y_in;
    mism_nxt      = mism + {{(MISMATCH_W-1){1'b0}}, miss};
  end

  sweep_dwell_timer #(.DWELL(DWELL)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept || sample),
    .en   (running),
    .last (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      code       <= '0;
      acc        <= '0;
      mism       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      table_q    <= '0;
      pass       <= 1'b0;
      mism_cnt_q <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, FINISH: begin
          if (bus.start) begin
            state <= RUN;
            code  <= '0;
            acc   <= '0;
            mism  <= '0;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (sample) begin
            acc  <= acc_nxt;
            mism <= mism_nxt;
            if (code == CODE_W'(NUM_CODES - 1)) begin
              state      <= FINISH;
              code       <= '0;
              busy       <= 1'b0;
              done       <= 1'b1;
              table_q    <= acc_nxt;
              mism_cnt_q <= mism_nxt;
              pass       <= (mism_nxt == '0);
            end else begin
              code <= code + CODE_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.A            = code[3];
  assign bus.B            = code[2];
  assign bus.C            = code[1];
  assign bus.D            = code[0];
  assign bus.busy         = busy;
  assign bus.done         = done;
  assign bus.table_out    = table_q;
  assign bus.pass         = pass;
  assign bus.mismatch_cnt = mism_cnt_q;
endmodule

// File: tb/tb_truth_table_sweep.sv
// Directed bench for truth_table_sweep with DWELL=4 and DWELL=1 instances.
module tb_truth_table_sweep;
  logic clk = 1'b0;
  logic rst;
  int   mode4;
  int   mode1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  truth_table_sweep_if if4 ();
  truth_table_sweep_if if1 ();

  truth_table_sweep #(.DWELL(4), .EXPECTED(16'h0040)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4.master)
  );

  truth_table_sweep #(.DWELL(1), .EXPECTED(16'h0040)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.master)
  );

  // 0: Y = ~A&B&C&~D, 1: stuck-at-0, 2: stuck-at-1
  function automatic logic model_y(input int mode, input logic [3:0] c);
    case (mode)
      0:       return ~c[3] & c[2] & c[1] & ~c[0];
      1:       return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  assign if4.y_in = model_y(mode4, {if4.A, if4.B, if4.C, if4.D});
  assign if1.y_in = model_y(mode1, {if1.A, if1.B, if1.C, if1.D});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Entered at the negedge of cycle k+1 (start seen at edge k);
  // leaves at the negedge of the done cycle.
  task automatic sweep4(input string tag, input logic [15:0] et, input logic ep,
                        input logic [4:0] em, input bit noisy, input logic [15:0] prev_t);
    int code_err = 0;
    int busy_err = 0;
    int done_err = 0;
    int hold_err = 0;
    for (int i = 0; i < 64; i++) begin
      if ({if4.A, if4.B, if4.C, if4.D} !== 4'(i / 4)) code_err++;
      if (if4.busy !== 1'b1) busy_err++;
      if (if4.done !== 1'b0) done_err++;
      if (if4.table_out !== prev_t) hold_err++;
      if4.start = (noisy && (i % 8 == 3)) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    if4.start = 1'b0;
    chk({tag, "_code_seq"}, code_err, 0);
    chk({tag, "_busy_len"}, busy_err, 0);
    chk({tag, "_early_done"}, done_err, 0);
    chk({tag, "_result_hold"}, hold_err, 0);
    chk({tag, "_done"}, if4.done, 1);
    chk({tag, "_busy_off"}, if4.busy, 0);
    chk({tag, "_abcd_idle"}, {if4.A, if4.B, if4.C, if4.D}, 0);
    chk({tag, "_table"}, if4.table_out, et);
    chk({tag, "_pass"}, if4.pass, ep);
    chk({tag, "_mismatch"}, if4.mismatch_cnt, em);
  endtask

  task automatic pulse_start4();
    @(negedge clk);
    if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
  endtask

  initial begin
    int done_seen;
    int err1;
    mode4     = 0;
    mode1     = 0;
    rst       = 1'b1;
    if4.start = 1'b1;
    if1.start = 1'b1;

    // Reset held with start asserted
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_busy", if4.busy, 0);
    end
    chk("rst_abcd", {if4.A, if4.B, if4.C, if4.D}, 0);
    chk("rst_done", if4.done, 0);
    chk("rst_table", if4.table_out, 16'h0000);
    chk("rst_pass", if4.pass, 0);
    chk("rst_mismatch", if4.mismatch_cnt, 0);
    chk("rst_busy1", if1.busy, 0);
    rst       = 1'b0;
    if4.start = 1'b0;
    if1.start = 1'b0;
    @(negedge clk);
    chk("idle_busy", if4.busy, 0);

    // Golden run
    mode4 = 0;
    pulse_start4();
    sweep4("gold", 16'h0040, 1'b1, 5'd0, 1'b0, 16'h0000);
    @(negedge clk);
    chk("gold_done_drop", if4.done, 0);

    // Stuck-at-0 with start pulses during busy, then start in the done cycle
    mode4 = 1;
    pulse_start4();
    sweep4("s0", 16'h0000, 1'b0, 5'd1, 1'b1, 16'h0040);
    mode4     = 2;
    if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    chk("chain_busy", if4.busy, 1);
    sweep4("s1", 16'hFFFF, 1'b0, 5'd15, 1'b0, 16'h0000);
    @(negedge clk);

    // Abort mid-sweep while code 7 is driven
    mode4 = 0;
    pulse_start4();
    repeat (28) @(negedge clk);
    chk("abort_code7", {if4.A, if4.B, if4.C, if4.D}, 7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_abcd", {if4.A, if4.B, if4.C, if4.D}, 0);
    chk("abort_busy", if4.busy, 0);
    chk("abort_table", if4.table_out, 16'h0000);
    chk("abort_mismatch", if4.mismatch_cnt, 0);
    done_seen = (if4.done === 1'b1) ? 1 : 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (if4.done === 1'b1) done_seen++;
    end
    chk("abort_no_done", done_seen, 0);
    pulse_start4();
    sweep4("after_abort", 16'h0040, 1'b1, 5'd0, 1'b0, 16'h0000);

    // DWELL = 1 golden run
    mode1 = 0;
    err1  = 0;
    @(negedge clk);
    if1.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if ({if1.A, if1.B, if1.C, if1.D} !== 4'(i)) err1++;
      if (if1.busy !== 1'b1) err1++;
      @(negedge clk);
    end
    chk("d1_seq", err1, 0);
    chk("d1_done", if1.done, 1);
    chk("d1_busy_off", if1.busy, 0);
    chk("d1_table", if1.table_out, 16'h0040);
    chk("d1_pass", if1.pass, 1);
    chk("d1_mismatch", if1.mismatch_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
